// File: rtl/instr_seq_if.sv
// Handshake/program bundle between the program sequencer and its surroundings.
// slave = sequencer side, master = host/controller side.
interface instr_seq_if #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 8
);
  logic          start;
  logic          step_mode;
  logic          step;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [DW+2:0] prog_wdata;
  logic          ctrl_done;
  logic          ctrl_idle;
  logic          execute;
  logic [2:0]    operation;
  logic [DW-1:0] operand;
  logic [AW-1:0] pc;
  logic          busy;
  logic          done;
  logic          timeout_err;

  modport slave (
    input  start, step_mode, step, prog_we, prog_addr, prog_wdata, ctrl_done, ctrl_idle,
    output execute, operation, operand, pc, busy, done, timeout_err
  );

  modport master (
    output start, step_mode, step, prog_we, prog_addr, prog_wdata, ctrl_done, ctrl_idle,
    input  execute, operation, operand, pc, busy, done, timeout_err
  );
endinterface

// File: rtl/instr_sequencer.sv
// Program sequencer: issues opcode/operand words to the datapath controller one at a time.
// Optional per-instruction watchdog enabled by defining SEQ_WATCHDOG_EN.
module instr_sequencer #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned AW      = 4,
  parameter int unsigned DW      = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst,
  instr_seq_if.slave   bus
);

  localparam int unsigned IW      = DW + 3;
  localparam logic [2:0]  OP_HALT = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT_DONE,
    S_RELEASE,
    S_PAUSE,
    S_HALT,
    S_ERR
  } state_t;

  state_t        r_state;
  logic [IW-1:0] r_mem [DEPTH];
  logic [IW-1:0] r_ir;
  logic [AW-1:0] r_pc;
  logic          r_execute;
  logic [2:0]    r_operation;
  logic [DW-1:0] r_operand;
  logic          r_busy;
  logic          r_done;
  logic          r_timeout_err;

  logic          w_quiet;
  logic          w_prog_wr;
  logic          w_wd_trip;

  assign w_quiet   = (r_state == S_IDLE) || (r_state == S_HALT) || (r_state == S_ERR);
  assign w_prog_wr = w_quiet && bus.prog_we;

  // Program memory survives reset, so it has no reset branch.
  always_ff @(posedge clk) begin
    if (w_prog_wr) begin
      r_mem[bus.prog_addr] <= bus.prog_wdata;
    end
  end

`ifdef SEQ_WATCHDOG_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_wd_cnt;

  // Counts cycles spent in WAIT_DONE + RELEASE; ISSUE clears it on the way in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wd_cnt <= '0;
    end else if ((r_state == S_WAIT_DONE) || (r_state == S_RELEASE)) begin
      r_wd_cnt <= r_wd_cnt + CW'(1);
    end else begin
      r_wd_cnt <= '0;
    end
  end

  assign w_wd_trip = ((r_state == S_WAIT_DONE) || (r_state == S_RELEASE)) &&
                     (r_wd_cnt == CW'(TIMEOUT - 1));
`else
  assign w_wd_trip = 1'b0 & (TIMEOUT == 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_ir          <= '0;
      r_pc          <= '0;
      r_execute     <= 1'b0;
      r_operation   <= 3'b000;
      r_operand     <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_HALT, S_ERR: begin
          // A program write in the same cycle takes precedence over start.
          if (bus.start && !bus.prog_we) begin
            r_pc          <= '0;
            r_done        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_busy        <= 1'b1;
            r_state       <= S_FETCH;
          end
        end

        S_FETCH: begin
          r_ir    <= r_mem[r_pc];
          r_state <= S_ISSUE;
        end

        S_ISSUE: begin
          if (r_ir[IW-1:DW] == OP_HALT) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_HALT;
          end else begin
            r_execute   <= 1'b1;
            r_operation <= r_ir[IW-1:DW];
            r_operand   <= r_ir[DW-1:0];
            r_state     <= S_WAIT_DONE;
          end
        end

        S_WAIT_DONE: begin
          if (w_wd_trip) begin
            r_execute     <= 1'b0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b1;
            r_state       <= S_ERR;
          end else if (bus.ctrl_done) begin
            r_execute <= 1'b0;
            r_state   <= S_RELEASE;
          end
        end

        S_RELEASE: begin
          if (w_wd_trip) begin
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b1;
            r_state       <= S_ERR;
          end else if (bus.ctrl_idle) begin
            // Last word of memory ends the program; pc never wraps.
            if (r_pc == AW'(DEPTH - 1)) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_HALT;
            end else begin
              r_pc    <= r_pc + AW'(1);
              r_state <= bus.step_mode ? S_PAUSE : S_FETCH;
            end
          end
        end

        S_PAUSE: begin
          if (bus.step) begin
            r_state <= S_FETCH;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.execute     = r_execute;
  assign bus.operation   = r_operation;
  assign bus.operand     = r_operand;
  assign bus.pc          = r_pc;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.timeout_err = r_timeout_err;

endmodule
